cnn_stage_sequencer: RTL and testbench

Top-level run controller for the one-bit-input CNN pattern-detection pipeline. On `go` it sequences stage engines 1..NUM_STAGES one at a time (start pulse, wait for done), exposes sticky per-stage completion flags and a final `done`, and guards against hung stages with a watchdog. It also arbitrates the single-port result memory between the active stage engine and the external display read port.

---
 rtl/cnn_stage_sequencer_pkg.sv | 23 ++
 rtl/cnn_stage_sequencer_if.sv | 44 ++++
 rtl/cnn_stage_sequencer_mem_port_arbiter.sv | 72 +++++++
 rtl/cnn_stage_sequencer.sv | 123 ++++++++++++
 tb/tb_cnn_stage_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_stage_sequencer_pkg.sv
// Shared definitions for the CNN stage sequencer: FSM encoding, default sizes
// and the helper that picks the final stage of a run.
package cnn_stage_sequencer_pkg;

  localparam int NUM_STAGES_DEF = 5;
  localparam int ADDR_W_DEF     = 17;
  localparam int TIMEOUT_W_DEF  = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } seq_state_t;

  // Index of the final stage: the last engine is skipped unless extra is set.
  function automatic int last_stage(input logic extra, input int num_stages);
    return extra ? (num_stages - 1) : (num_stages - 2);
  endfunction

endpackage

// File: rtl/cnn_stage_sequencer_if.sv
// Control, stage-engine handshake and result-memory signals of the sequencer.
// slave = sequencer view, master = environment (stage engines, memory, display).
interface cnn_stage_sequencer_if
  import cnn_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
);

  logic                  go;
  logic                  extra;
  logic [NUM_STAGES-1:0] stg_start;
  logic [NUM_STAGES-1:0] stg_done;
  logic [NUM_STAGES-1:0] stage;
  logic                  done;
  logic                  busy;
  logic                  error;
  logic                  eng_req;
  logic [ADDR_W-1:0]     eng_addr;
  logic                  eng_gnt;
  logic                  ena_display;
  logic                  read_display;
  logic [ADDR_W-1:0]     addr_display;
  logic                  mem_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_dout;
  logic                  dout_display;
  logic                  dout_valid;

  modport slave (
    input  go, extra, stg_done, eng_req, eng_addr,
           ena_display, read_display, addr_display, mem_dout,
    output stg_start, stage, done, busy, error, eng_gnt,
           mem_en, mem_addr, dout_display, dout_valid
  );

  modport master (
    output go, extra, stg_done, eng_req, eng_addr,
           ena_display, read_display, addr_display, mem_dout,
    input  stg_start, stage, done, busy, error, eng_gnt,
           mem_en, mem_addr, dout_display, dout_valid
  );

endinterface

// File: rtl/cnn_stage_sequencer_mem_port_arbiter.sv
// Single-port result-memory arbiter: engine wins while a run is busy, display
// reads are served otherwise and their data returns through a 2-stage pipe.
module mem_port_arbiter
  import cnn_stage_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              i_eng_req,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic              i_ena_display,
  input  logic              i_read_display,
  input  logic [ADDR_W-1:0] i_addr_display,
  input  logic              i_mem_dout,
  output logic              o_eng_gnt,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_dout_display,
  output logic              o_dout_valid
);

  logic w_disp_acc_p0;
  logic r_vld_p1;
  logic r_vld_p2;
  logic r_dout_p2;

  always_comb begin
    o_eng_gnt     = 1'b0;
    o_mem_en      = 1'b0;
    o_mem_addr    = '0;
    w_disp_acc_p0 = 1'b0;
    if (i_busy) begin
      o_eng_gnt = i_eng_req;
      o_mem_en  = i_eng_req;
      if (i_eng_req) begin
        o_mem_addr = i_eng_addr;
      end
    end else if (i_ena_display && i_read_display) begin
      w_disp_acc_p0 = 1'b1;
      o_mem_en      = 1'b1;
      o_mem_addr    = i_addr_display;
    end
  end

  // p0 -> p1: memory is reading the accepted display address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_disp_acc_p0;
    end
  end

  // p1 -> p2: capture memory data, valid follows it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p2  <= 1'b0;
      r_dout_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_dout_p2 <= i_mem_dout;
      end
    end
  end

  assign o_dout_display = r_dout_p2;
  assign o_dout_valid   = r_vld_p2;

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Run controller: starts stage engines one at a time, tracks completion with a
// watchdog per stage, and shares the result memory with the display port.
module cnn_stage_sequencer
  import cnn_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  cnn_stage_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [TIMEOUT_W-1:0]  r_wdog;
  logic [NUM_STAGES-1:0] r_stage;

  logic [NUM_STAGES-1:0] w_idx_oh;
  logic [IDX_W-1:0]      w_last_idx;
  logic                  w_last;
  logic                  w_done_sel;
  logic [TIMEOUT_W-1:0]  w_wdog_inc;
  logic                  w_wdog_full;
  logic                  w_busy;

  assign w_idx_oh    = NUM_STAGES'(1) << r_idx;
  assign w_last_idx  = IDX_W'(last_stage(bus.extra, NUM_STAGES));
  assign w_last      = (r_idx == w_last_idx);
  // Only the active stage's done bit counts; strays from other engines are masked.
  assign w_done_sel  = |(bus.stg_done & w_idx_oh);
  assign w_wdog_inc  = r_wdog + TIMEOUT_W'(1);
  assign w_wdog_full = &w_wdog_inc;
  assign w_busy      = (r_state == S_START) || (r_state == S_WAIT) ||
                       (r_state == S_NEXT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.go) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_sel) begin
          w_state_nxt = S_NEXT;
        end else if (w_wdog_full) begin
          w_state_nxt = S_ERR;
        end
      end
      S_NEXT:  w_state_nxt = w_last ? S_DONE : S_START;
      S_DONE:  if (!bus.go) w_state_nxt = S_IDLE;
      S_ERR:   if (!bus.go) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_wdog  <= '0;
      r_stage <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.go) begin
            r_idx   <= '0;
            r_stage <= '0;
          end
        end
        S_START: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= w_wdog_inc;
          if (w_done_sel) begin
            r_stage <= r_stage | w_idx_oh;
          end
        end
        S_NEXT: begin
          if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stg_start = (r_state == S_START) ? w_idx_oh : '0;
  assign bus.stage     = r_stage;
  assign bus.done      = (r_state == S_DONE);
  assign bus.busy      = w_busy;
  assign bus.error     = (r_state == S_ERR);

  mem_port_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .clk            (clk),
    .rst            (rst),
    .i_busy         (w_busy),
    .i_eng_req      (bus.eng_req),
    .i_eng_addr     (bus.eng_addr),
    .i_ena_display  (bus.ena_display),
    .i_read_display (bus.read_display),
    .i_addr_display (bus.addr_display),
    .i_mem_dout     (bus.mem_dout),
    .o_eng_gnt      (bus.eng_gnt),
    .o_mem_en       (bus.mem_en),
    .o_mem_addr     (bus.mem_addr),
    .o_dout_display (bus.dout_display),
    .o_dout_valid   (bus.dout_valid)
  );

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Scoreboard bench for cnn_stage_sequencer: expected stage starts and display
// read data are queued when stimulus is driven and retired as the DUT responds.
module tb_cnn_stage_sequencer;

  localparam int NS  = 5;
  localparam int AW  = 17;
  localparam int TW  = 4;
  localparam int DLY = 10;

  typedef struct {
    int   cyc;
    logic d;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [NS-1:0] sq[$];
  rd_t           dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW)) bus();

  cnn_stage_sequencer #(
    .NUM_STAGES (NS),
    .ADDR_W     (AW),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: bit stored at address a is a[0], one-cycle read latency.
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.mem_dout <= 1'b0;
    else if (bus.mem_en) bus.mem_dout <= bus.mem_addr[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic await_start(input int max_t, output int n);
    n = 0;
    while (bus.stg_start == '0 && n < max_t) begin
      tick();
      n++;
    end
  endtask

  task automatic start_check(input string tag, input int n, input int n_exp);
    logic [NS-1:0] e;
    if (sq.size() == 0) begin
      chk({tag, "_unexp"}, 1, 0);
    end else begin
      e = sq.pop_front();
      chk(tag, bus.stg_start, e);
      chk({tag, "_lat"}, n, n_exp);
    end
  endtask

  // Entered in the START cycle of stage k; leaves in the following NEXT cycle.
  // stray=1: done[k] on the start cycle; stray=2: done[3] mid-wait.
  task automatic stage_body(input int k, input int stray);
    logic seen;
    seen = 1'b0;
    if (stray == 1) bus.stg_done = NS'(1) << k;
    for (int i = 1; i <= DLY; i++) begin
      tick();
      bus.stg_done = '0;
      if (bus.stg_start != '0) seen = 1'b1;
      if (i == 1) chk($sformatf("busy_wait%0d", k), bus.busy, 1);
      if (stray == 2 && i == 3) bus.stg_done = 5'b01000;
    end
    chk($sformatf("no_early_start%0d", k), seen, 0);
    bus.stg_done = NS'(1) << k;
    tick();
    bus.stg_done = '0;
    chk($sformatf("stage_bit%0d", k), bus.stage[k], 1);
  endtask

  always @(negedge clk) begin
    if (rst && bus.dout_valid) begin
      if (dq.size() == 0) begin
        chk("dvalid_unexp", 1, 0);
      end else begin
        rd_t e;
        e = dq.pop_front();
        chk("dvalid_cyc", cyc, e.cyc);
        chk("dout_data", bus.dout_display, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [NS-1:0] acc;
    rst = 1'b0;
    bus.go = 1'b0; bus.extra = 1'b0; bus.stg_done = '0;
    bus.eng_req = 1'b0; bus.eng_addr = '0;
    bus.ena_display = 1'b0; bus.read_display = 1'b0; bus.addr_display = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {bus.stg_start, bus.stage, bus.done, bus.busy, bus.error}, 0);
    chk("rst_mem", {bus.eng_gnt, bus.mem_en, bus.mem_addr, bus.dout_display, bus.dout_valid}, 0);
    rst = 1'b1;
    tick(); tick();
    chk("idle_ctl", {bus.stg_start, bus.done, bus.busy, bus.error}, 0);

    // Full run, all five stages
    bus.extra = 1'b1; bus.go = 1'b1;
    for (int k = 0; k < NS; k++) sq.push_back(NS'(1) << k);
    tick();
    for (int k = 0; k < NS; k++) begin
      await_start(30, n);
      start_check($sformatf("full_start%0d", k), n, (k == 0) ? 0 : 1);
      stage_body(k, 0);
    end
    tick();
    chk("full_done", {bus.done, bus.busy, bus.error}, 3'b100);
    chk("full_stage", bus.stage, 5'b11111);
    repeat (3) tick();
    chk("done_hold", bus.done, 1);

    bus.eng_req = 1'b1; bus.eng_addr = 17'h00010;
    #1;
    chk("idle_eng_ignored", {bus.eng_gnt, bus.mem_en}, 0);
    bus.eng_req = 1'b0;

    bus.ena_display = 1'b1; bus.read_display = 1'b1; bus.addr_display = 17'd5;
    #1;
    chk("disp_rd5", {bus.mem_en, bus.eng_gnt, bus.mem_addr}, {1'b1, 1'b0, 17'd5});
    dq.push_back('{cyc + 2, 1'b1});
    tick();
    bus.addr_display = 17'd6;
    #1;
    chk("disp_rd6", {bus.mem_en, bus.mem_addr}, {1'b1, 17'd6});
    dq.push_back('{cyc + 2, 1'b0});
    tick();
    bus.read_display = 1'b0; bus.ena_display = 1'b0;
    #1;
    chk("disp_idle", {bus.mem_en, bus.mem_addr}, 0);
    repeat (4) tick();
    chk("dq_drained", dq.size(), 0);

    bus.go = 1'b0;
    tick();
    chk("idle_after_done", {bus.done, bus.busy}, 0);
    chk("stage_retained", bus.stage, 5'b11111);

    // Short run with stray done pulses and busy-time arbitration
    bus.extra = 1'b0; bus.go = 1'b1;
    for (int k = 0; k < NS - 1; k++) sq.push_back(NS'(1) << k);
    tick();
    for (int k = 0; k < NS - 1; k++) begin
      await_start(30, n);
      start_check($sformatf("short_start%0d", k), n, (k == 0) ? 0 : 1);
      if (k == 0) begin
        bus.eng_req = 1'b1; bus.eng_addr = 17'h00010;
        bus.ena_display = 1'b1; bus.read_display = 1'b1; bus.addr_display = 17'h1ABCD;
        #1;
        chk("busy_arb", {bus.eng_gnt, bus.mem_en, bus.mem_addr}, {1'b1, 1'b1, 17'h00010});
        chk("short_stage_clr", bus.stage, 0);
      end
      stage_body(k, (k == 0) ? 1 : ((k == 1) ? 2 : 0));
      if (k == 0) begin
        bus.eng_req = 1'b0;
        #1;
        chk("busy_noeng", {bus.eng_gnt, bus.mem_en, bus.mem_addr}, 0);
        bus.ena_display = 1'b0; bus.read_display = 1'b0;
      end
    end
    tick();
    chk("short_done", {bus.done, bus.busy}, 2'b10);
    chk("short_stage", bus.stage, 5'b01111);
    acc = '0;
    repeat (4) begin
      acc |= bus.stg_start;
      tick();
    end
    chk("no_start4", acc, 0);
    bus.go = 1'b0;
    tick();

    // Watchdog: stage 2 never completes
    bus.extra = 1'b1; bus.go = 1'b1;
    sq.push_back(5'b00001); sq.push_back(5'b00010);
    tick();
    await_start(30, n);
    start_check("wd_start0", n, 0);
    stage_body(0, 0);
    await_start(30, n);
    start_check("wd_start1", n, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("wd_pre", {bus.error, bus.busy}, 2'b01);
      if (i == 16) chk("wd_err", {bus.error, bus.busy}, 2'b10);
    end
    repeat (3) tick();
    chk("err_hold", {bus.error, bus.stg_start}, {1'b1, 5'b00000});
    bus.go = 1'b0;
    tick();
    chk("err_clear", {bus.error, bus.busy, bus.done}, 0);
    chk("err_stage", bus.stage, 5'b00001);

    // Asynchronous reset in the middle of WAIT
    bus.go = 1'b1;
    sq.push_back(5'b00001);
    tick();
    await_start(30, n);
    start_check("pre_rst_start0", n, 0);
    repeat (3) tick();
    chk("pre_rst_busy", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {bus.stg_start, bus.stage, bus.done, bus.busy, bus.error}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sq.push_back(5'b00001);
    tick();
    await_start(30, n);
    start_check("restart0", n, 0);
    bus.go = 1'b0;
    tick();
    chk("sq_empty", sq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
